// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity codes
// and the default payload width.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and data-bit counter; ser_bit is the next LSB to put
// on the line and ser_done flags the cycle in which the last data bit is out.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  shift,
    input  logic                  active,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

    // bit_cnt is the index of the data bit currently on the line while active;
    // it wraps to zero as the last bit leaves so the next frame starts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= data;
            bit_cnt <= '0;
        end else begin
            if (shift) begin
                shreg <= shreg >> 1;
            end
            if (active) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
            end
        end
    end

    assign ser_bit  = shreg[0];
    assign ser_done = active && (bit_cnt == LAST_BIT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, parity and registered line driver.
// Define UART_TX_PARITY_EN to compile in the optional parity bit.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy,
    output tx_state_t             state
);

    // Request semantics: data_valid is a level sampled only while IDLE; the
    // edge that sees it high is the accept edge, and the start bit occupies
    // the very next bit period. There is no back-pressure signal other than busy.

    tx_state_t state_next;
    logic      tx_next;
    logic      busy_next;
    logic      load;
    logic      shift;
    logic      ser_active;
    logic      ser_bit;
    logic      ser_done;

    assign ser_active = (state == ST_DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (p_data),
        .shift    (shift),
        .active   (ser_active),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit_q;

    // The payload is shifted away during DATA, so the parity bit is resolved
    // from par_typ and p_data at the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (load) begin
            par_en_q  <= par_en;
            par_bit_q <= (par_typ == PAR_ODD) ? ~(^p_data) : (^p_data);
        end
    end
`else
    logic unused_par_inputs;
    assign unused_par_inputs = par_en ^ par_typ;
`endif

    // Next-state and next-output decode; outputs are registered together with
    // the state so tx_out and busy always describe the current state.
    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (data_valid) begin
                    load       = 1'b1;
                    state_next = ST_START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            ST_START: begin
                state_next = ST_DATA;
                tx_next    = ser_bit;
                busy_next  = 1'b1;
                shift      = 1'b1;
            end
            ST_DATA: begin
                busy_next = 1'b1;
                if (ser_done) begin
`ifdef UART_TX_PARITY_EN
                    if (par_en_q) begin
                        state_next = ST_PARITY;
                        tx_next    = par_bit_q;
                    end else begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end
`else
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
`endif
                end else begin
                    tx_next = ser_bit;
                    shift   = 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                state_next = ST_STOP;
                tx_next    = 1'b1;
                busy_next  = 1'b1;
            end
`endif
            ST_STOP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            tx_out <= tx_next;
            busy   <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame-level queue model checked every
// cycle, plus directed frames compared against hand-built bit patterns.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  p_data = '0;
    logic          data_valid = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          tx_out;
    logic          busy;
    tx_state_t     state;

    int checks = 0;
    int failures = 0;

    // Model: one {tx_out, busy} entry per future bit period.
    logic [1:0] exp_q[$];
    logic [1:0] exp_cur = 2'b10;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy),
        .state      (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model step: a whole frame is queued at the accept edge, ending with the
    // IDLE period during which the next request may be sampled.
    task automatic model_step();
        logic par_bit;
        if (!rst) begin
            exp_q.delete();
            exp_cur = 2'b10;
        end else if (exp_q.size() != 0) begin
            exp_cur = exp_q.pop_front();
        end else if (data_valid) begin
            exp_cur = 2'b01;
            for (int i = 0; i < W; i++) exp_q.push_back({p_data[i], 1'b1});
            par_bit = par_typ ? ~(^p_data) : (^p_data);
            if (PAR_BUILT && par_en) exp_q.push_back({par_bit, 1'b1});
            exp_q.push_back(2'b11);
            exp_q.push_back(2'b10);
        end else begin
            exp_cur = 2'b10;
        end
    endtask

    task automatic send_capture(input logic [7:0] d, input logic pe, input logic pt,
                                input int pulse_at, output logic [13:0] bits,
                                output int busy_n);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        bits   = '0;
        busy_n = 0;
        for (int i = 0; i < 14; i++) begin
            bits[i] = tx_out;
            busy_n += int'(busy);
            if (i == pulse_at) begin
                data_valid = 1'b1;
                p_data     = 8'h3C;
                par_en     = ~pe;
                par_typ    = ~pt;
            end else if (i == pulse_at + 1) begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
    endtask

    initial begin
        logic [13:0] bits;
        logic [31:0] b2b;
        int          busy_n;

        fork
            forever begin
                @(posedge clk or negedge rst);
                model_step();
            end
            forever begin
                @(negedge clk);
                check("cycle_tx_busy", 32'({tx_out, busy}), 32'(exp_cur));
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_out), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_state", 32'(state), 32'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);

        // 0xA5 without parity
        send_capture(8'hA5, 1'b0, 1'b0, -1, bits, busy_n);
        check("a5_frame", 32'(bits), 32'(14'b1111_1101001010));
        check("a5_busy_len", 32'(busy_n), 32'd10);

        // 0xA5 even / odd, 0x00 odd, 0xFF even
        send_capture(8'hA5, 1'b1, PAR_EVEN, -1, bits, busy_n);
        check("a5_even_frame", 32'(bits),
              PAR_BUILT ? 32'(14'b111_10101001010) : 32'(14'b1111_1101001010));
        check("a5_even_busy", 32'(busy_n), PAR_BUILT ? 32'd11 : 32'd10);
        send_capture(8'hA5, 1'b1, PAR_ODD, -1, bits, busy_n);
        check("a5_odd_frame", 32'(bits),
              PAR_BUILT ? 32'(14'b111_11101001010) : 32'(14'b1111_1101001010));
        send_capture(8'h00, 1'b1, PAR_ODD, -1, bits, busy_n);
        check("00_odd_frame", 32'(bits),
              PAR_BUILT ? 32'(14'b111_11000000000) : 32'(14'b1111_1000000000));
        send_capture(8'hFF, 1'b1, PAR_EVEN, -1, bits, busy_n);
        check("ff_even_frame", 32'(bits),
              PAR_BUILT ? 32'(14'b111_10111111110) : 32'(14'b1111_1111111110));

        // Mid-frame request during DATA is ignored
        send_capture(8'hA5, 1'b0, 1'b0, 3, bits, busy_n);
        check("ignore_pulse_frame", 32'(bits), 32'(14'b1111_1101001010));
        check("ignore_pulse_busy", 32'(busy_n), 32'd10);

        // Reset on the 4th data bit aborts the frame at once
        p_data     = 8'hA5;
        par_en     = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_abort_bit3", 32'({tx_out, busy}), 32'(2'b01));
        #2;
        rst = 1'b0;
        #1;
        check("abort_tx", 32'(tx_out), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_state", 32'(state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_capture(8'h81, 1'b0, 1'b0, -1, bits, busy_n);
        check("post_reset_81", 32'(bits), 32'(14'b1111_1100000010));

        // data_valid held high: back-to-back frames, one idle clk between
        p_data     = 8'h5A;
        par_en     = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        b2b = '0;
        for (int i = 0; i < 24; i++) begin
            b2b[i] = tx_out;
            @(negedge clk);
        end
        data_valid = 1'b0;
        check("b2b_gap1", 32'(b2b[11:9]), 32'(3'b011));
        check("b2b_gap2", 32'(b2b[22:20]), 32'(3'b011));
        check("b2b_frame1", 32'(b2b[9:0]), 32'(10'b1010110100));
        repeat (16) @(negedge clk);
        check("final_idle", 32'({tx_out, busy}), 32'(2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, payload bits per frame.
REQ-002 clk  input  1  TX bit clock; one clk period equals one bit period.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 p_data  input  DATA_WIDTH  parallel payload to transmit.
REQ-005 data_valid  input  1  request to send p_data; sampled only in IDLE.
REQ-006 par_en  input  1  when high, a parity bit is inserted after the data bits.
REQ-007 par_typ  input  1  parity type: 0 even, 1 odd.
REQ-008 tx_out  output  1  serial line; idle level is high.
REQ-009 busy  output  1  high while a frame is in progress.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, with every output registered.
REQ-011 In IDLE with data_valid=1, the block SHALL latch p_data, par_en and par_typ, then enter START on the next edge.
REQ-012 data_valid SHALL be ignored in every state other than IDLE, and input changes mid-frame SHALL NOT affect the frame.
REQ-013 START SHALL drive tx_out=0 for exactly one clk.
REQ-014 DATA SHALL drive the latched bits LSB first, one per clk, for DATA_WIDTH clks, using a bit counter 0..DATA_WIDTH-1.
REQ-015 After the last data bit, the FSM SHALL go to PARITY if the latched par_en=1, else to STOP.
REQ-016 PARITY SHALL drive ^data for even and ~^data for odd, for one clk.
REQ-017 STOP SHALL drive tx_out=1 for one clk.
REQ-018 From STOP, the FSM SHALL return to IDLE; a new data_valid is then accepted no earlier than the IDLE cycle.
REQ-019 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-020 Frame length SHALL be DATA_WIDTH+2 clks, or DATA_WIDTH+3 with parity; latency from the accept edge to the start bit on tx_out is 1 clk.
REQ-021 tx_out SHALL be 1 in IDLE.

Reset
REQ-022 On rst=0, the block SHALL force state=IDLE, tx_out=1, busy=0, bit counter=0 and latched data=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately and release the line high; there is no resumption.

Configuration
REQ-024 Macro UART_TX_PARITY_EN: when defined, the PARITY state and parity logic are compiled in and par_en/par_typ behave per REQ-015/016.
REQ-025 When UART_TX_PARITY_EN is undefined, the ports remain present but are ignored, PARITY is unreachable, and every frame is DATA_WIDTH+2 clks.

Structure
REQ-026 The shared package uart_pkg SHALL hold the FSM state encoding, the PAR_EVEN/PAR_ODD codes, and the default DATA_WIDTH.
REQ-027 One sub-module, uart_tx_serializer, SHALL contain the data shift register and bit counter and SHALL assert ser_done on the last data bit.
REQ-028 The FSM, parity computation and output mux SHALL reside in uart_tx_ctrl.

Verification
REQ-029 No parity, 0xA5: tx_out = 0,1,0,1,0,0,1,0,1,1, busy high for 10 clks, then tx_out=1 and busy=0.
REQ-030 par_en=1, par_typ=0, 0xA5: the parity bit after the data bits is 0 (11 clks); with par_typ=1 the parity bit is 1.
REQ-031 0x00 with odd parity produces parity 1; 0xFF with even parity produces parity 0.
REQ-032 data_valid pulsed with 0x3C during DATA of an 0xA5 frame: the pulse is ignored and only 0xA5 is sent.
REQ-033 rst=0 on the 4th data bit: tx_out=1 and busy=0 immediately; after release, an 0x81 request is sent correctly.
REQ-034 data_valid held high continuously: frames are sent back-to-back with exactly one idle-high clk between the STOP bit and the next START bit.
